// File: rtl/manchester_pkg.sv
// Shared types and line-coding constants for the Manchester receive path.
// Optional build macro MANCH_RX_ERR_CNT_EN is consumed by manchester_serial_rx.
package manchester_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA
   } rx_state_t;

   localparam int MANCH_DATA_BITS = 8;

   localparam logic ZERO_FIRST_HALF = 1'b1;
   localparam logic ONE_FIRST_HALF  = 1'b0;
   localparam logic IDLE_LEVEL      = 1'b0;

endpackage

// File: rtl/manchester_rx_sync.sv
// Two-flop synchronizer for the Manchester line plus a registered copy
// that yields rise and any-edge strobes on the synchronized level.
module manchester_rx_sync
   import manchester_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic serial_in,
   output logic line,
   output logic rise,
   output logic any_edge
);

   logic [1:0] meta;
   logic       prev;
   logic       fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= {2{IDLE_LEVEL}};
         prev <= IDLE_LEVEL;
      end else begin
         meta <= {meta[0], serial_in};
         prev <= meta[1];
      end
   end

   assign line     = meta[1];
   assign rise     = line & ~prev;
   assign fall     = ~line & prev;
   assign any_edge = rise | fall;

endmodule

// File: rtl/manchester_serial_rx.sv
// Manchester receiver: start bit plus MSB-first payload, mid-bit resync.
// Define MANCH_RX_ERR_CNT_EN to add the saturating err_count output.
module manchester_serial_rx
   import manchester_pkg::*;
#(
   parameter int HALF_BIT_CYCLES = 8,
   parameter int DATA_BITS       = MANCH_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 serial_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
`ifdef MANCH_RX_ERR_CNT_EN
   ,
   output logic [15:0]          err_count
`endif
);

   localparam int BIT_CYCLES = 2 * HALF_BIT_CYCLES;
   localparam int PW = $clog2(BIT_CYCLES);
   localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam int HQ = HALF_BIT_CYCLES / 2;

   localparam logic [PW-1:0] PH_A    = PW'(HQ);
   localparam logic [PW-1:0] PH_B    = PW'(HALF_BIT_CYCLES + HQ);
   localparam logic [PW-1:0] WIN_LO  = PW'(HQ + 1);
   localparam logic [PW-1:0] WIN_HI  = PW'(HALF_BIT_CYCLES + HQ - 1);
   localparam logic [PW-1:0] PH_RSYN = PW'(HALF_BIT_CYCLES + 1);
   localparam logic [PW-1:0] PH_LAST = PW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

   rx_state_t            state;
   logic [PW-1:0]        phase;
   logic [PW-1:0]        phase_inc;
   logic [CW-1:0]        bit_cnt;
   logic [DATA_BITS-2:0] shreg;
   logic [DATA_BITS-1:0] byte_nxt;
   logic                 samp_a;
   logic                 line;
   logic                 rise;
   logic                 any_edge;
   logic                 at_a;
   logic                 at_b;
   logic                 resync;
   logic                 bit_val;

   manchester_rx_sync u_sync (
      .clk      (clk),
      .rst      (rst),
      .serial_in(serial_in),
      .line     (line),
      .rise     (rise),
      .any_edge (any_edge)
   );

   assign phase_inc = (phase == PH_LAST) ? '0 : phase + 1'b1;
   assign at_a      = (phase == PH_A);
   assign at_b      = (phase == PH_B);
   assign resync    = any_edge && (phase >= WIN_LO) && (phase <= WIN_HI);
   assign bit_val   = (samp_a == ONE_FIRST_HALF);
   assign byte_nxt  = {shreg, bit_val};

   // The edge cycle itself is taken as the mid-bit point, so the
   // following cycle is HALF+1, matching the phase=1 start from IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         phase      <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         samp_a     <= IDLE_LEVEL;
         data_out   <= '0;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
         phase      <= resync ? PH_RSYN : phase_inc;
         if (at_a)
            samp_a <= line;
         unique case (state)
            IDLE: begin
               phase <= '0;
               if (rise) begin
                  phase <= PW'(1);
                  state <= START;
                  busy  <= 1'b1;
               end
            end
            START: begin
               if (at_a && line == IDLE_LEVEL) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else if (at_b) begin
                  if (samp_a == ZERO_FIRST_HALF &&
                      line != ZERO_FIRST_HALF) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end
               end
            end
            DATA: begin
               if (at_b) begin
                  if (line == samp_a) begin
                     frame_err <= 1'b1;
                     state     <= IDLE;
                     busy      <= 1'b0;
                  end else begin
                     shreg   <= byte_nxt[DATA_BITS-2:0];
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == LAST_BIT) begin
                        data_out   <= byte_nxt;
                        data_valid <= 1'b1;
                        state      <= START;
                     end
                  end
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

`ifdef MANCH_RX_ERR_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)
         err_count <= '0;
      else if (frame_err && err_count != 16'hFFFF)
         err_count <= err_count + 16'd1;
   end
`endif

endmodule
